// File: rtl/alu_exec_unit.sv
// alu_exec_unit
//   Registered, handshaked responder around the 16-bit ALU datapath. Takes one
//   request (inst_id, in0, in1) over valid/ready, computes the result and the
//   zero/pos/ovf/illegal flags, and presents them on a response channel. The
//   response is held until the consumer takes it. Also counts completed ops.
//
// Ports
//   clk        rising-edge clock for all state
//   reset      synchronous, active-high, clears all state
//   req_valid  request present on inst_id/in0/in1
//   req_ready  unit can accept a request (IDLE only)
//   inst_id    operation select, latched on accept
//   in0, in1   operands A and B, latched on accept
//   resp_valid out/flags valid (DONE only), held until resp_ready
//   resp_ready consumer takes the response
//   out        result
//   zero       out == 0
//   pos        out is strictly positive as a signed value
//   ovf        signed overflow of add/sub
//   illegal    inst_id was an unsupported code
//   op_count   completed responses since reset, wraps
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a request; out/flags keep the previous response
// EXEC  | operands latched; result and flags registered at end of state
// DONE  | response presented, held until resp_ready
module alu_exec_unit #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       inst_id,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             pos,
  output logic             ovf,
  output logic             illegal,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] out_q, res_d;
  logic             zero_q, pos_q, ovf_q, illegal_q;
  logic             zero_d, pos_d, ovf_d, illegal_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] sum, diff;
  logic             accept, consume;

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == DONE);
  assign accept     = req_valid & req_ready;
  assign consume    = resp_valid & resp_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)  state_d = EXEC;
      EXEC:                 state_d = DONE;
      DONE:    if (consume) state_d = IDLE;
      default:              state_d = IDLE;
    endcase
  end

  // Carry out of the top bit is dropped; results are modulo 2^WIDTH.
  assign sum  = a_q + b_q;
  assign diff = a_q - b_q;

  always_comb begin
    res_d     = '0;
    ovf_d     = 1'b0;
    illegal_d = 1'b0;
    case (op_q)
      4'b0001, 4'b0010, 4'b0011, 4'b0101, 4'b1100: begin
        res_d = diff;
        ovf_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
      end
      4'b1101: res_d = b_q;
      4'b1110, 4'b1111: illegal_d = 1'b1;
      default: begin
        res_d = sum;
        ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
    endcase
  end

  // Illegal codes leave res_d at zero, so zero=1/pos=0 fall out naturally.
  assign zero_d = (res_d == '0);
  assign pos_d  = !res_d[WIDTH-1] && !zero_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      out_q     <= '0;
      zero_q    <= 1'b0;
      pos_q     <= 1'b0;
      ovf_q     <= 1'b0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q <= inst_id;
        a_q  <= in0;
        b_q  <= in1;
      end
      if (state_q == EXEC) begin
        out_q     <= res_d;
        zero_q    <= zero_d;
        pos_q     <= pos_d;
        ovf_q     <= ovf_d;
        illegal_q <= illegal_d;
      end
      if (consume) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign out      = out_q;
  assign zero     = zero_q;
  assign pos      = pos_q;
  assign ovf      = ovf_q;
  assign illegal  = illegal_q;
  assign op_count = cnt_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit
//   Self-checking bench for alu_exec_unit: reset behaviour, reset during
//   EXEC/DONE, a table of directed vectors, a backpressure sequence and
//   randomized operations checked against an arithmetic reference model.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  inst_id = '0;
  logic [15:0] in0 = '0;
  logic [15:0] in1 = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [15:0] out;
  logic        zero, pos, ovf, illegal;
  logic [15:0] op_count;

  always #5 clk = ~clk;

  alu_exec_unit #(.WIDTH(16), .CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .inst_id    (inst_id),
    .in0        (in0),
    .in1        (in1),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .out        (out),
    .zero       (zero),
    .pos        (pos),
    .ovf        (ovf),
    .illegal    (illegal),
    .op_count   (op_count)
  );

  typedef struct packed {
    logic [15:0] out;
    logic        zero;
    logic        pos;
    logic        ovf;
    logic        ill;
  } res_t;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    res_t        e;
  } vec_t;

  int   n_total = 0;
  int   n_pass  = 0;
  int   exp_cnt = 0;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference model: signed integer arithmetic, overflow = result outside 16-bit signed range.
  function automatic res_t model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    res_t r;
    int   sa, sb, v;
    r  = '0;
    sa = int'($signed(a));
    sb = int'($signed(b));
    v  = 0;
    if (op inside {4'd14, 4'd15}) r.ill = 1'b1;
    else if (op == 4'd13) v = sb;
    else if (op inside {4'd1, 4'd2, 4'd3, 4'd5, 4'd12}) v = sa - sb;
    else v = sa + sb;
    if (!(op inside {4'd13, 4'd14, 4'd15})) r.ovf = (v > 32767) || (v < -32768);
    r.out  = 16'(v);
    r.zero = (r.out == 16'd0);
    r.pos  = ($signed(r.out) > 16'sd0);
    return r;
  endfunction

  task automatic push(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] o, input logic z, input logic p, input logic v,
                      input logic i);
    vec_t t;
    t.op = op; t.a = a; t.b = b;
    t.e.out = o; t.e.zero = z; t.e.pos = p; t.e.ovf = v; t.e.ill = i;
    vecs.push_back(t);
  endtask

  // Present one request from IDLE and wait (bounded) for the response.
  // edges counts rising edges from raising req_valid until resp_valid is seen.
  task automatic issue_wait(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                            output bit got, output int edges);
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; inst_id = op; in0 = a; in1 = b;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    inst_id = 4'($urandom); in0 = 16'($urandom); in1 = 16'($urandom);
    edges = 1;
    while (!resp_valid && edges < 10) begin
      @(negedge clk);
      edges++;
    end
    got = resp_valid;
    chk("resp_timeout", got, 1);
  endtask

  task automatic check_resp(input string tag, input res_t e);
    chk({tag, ".out"}, out, e.out);
    chk({tag, ".zero"}, zero, e.zero);
    chk({tag, ".pos"}, pos, e.pos);
    chk({tag, ".ovf"}, ovf, e.ovf);
    chk({tag, ".illegal"}, illegal, e.ill);
  endtask

  task automatic consume();
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    exp_cnt = (exp_cnt + 1) % 65536;
    chk("op_count", op_count, exp_cnt);
    chk("post_resp_valid", resp_valid, 0);
    chk("post_req_ready", req_ready, 1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit   got;
    int   edges;
    res_t e;
    logic [3:0]  op;
    logic [15:0] a, b;
    logic [15:0] corner[6];
    logic [3:0]  add_codes[7];
    logic [3:0]  sub_codes[5];
    corner    = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h8001};
    add_codes = '{4'd0, 4'd4, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11};
    sub_codes = '{4'd1, 4'd2, 4'd3, 4'd5, 4'd12};

    // Reset held for two cycles
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst.req_ready", req_ready, 1);
    chk("rst.resp_valid", resp_valid, 0);
    check_resp("rst", '0);
    chk("rst.op_count", op_count, 0);

    // Reset while in EXEC: response discarded
    @(negedge clk);
    req_valid = 1'b1; inst_id = 4'd0; in0 = 16'd3; in1 = 16'd4;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("exec.req_ready", req_ready, 0);
    chk("exec.resp_valid", resp_valid, 0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_exec.req_ready", req_ready, 1);
    chk("rst_exec.op_count", op_count, exp_cnt);
    for (int i = 0; i < 3; i++) begin
      chk("rst_exec.no_resp", resp_valid, 0);
      @(negedge clk);
    end

    // Reset while in DONE, with resp_ready also high: reset wins
    issue_wait(4'd0, 16'd5, 16'd5, got, edges);
    chk("done.out", out, 16'd10);
    @(negedge clk);
    reset = 1'b1; resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; resp_ready = 1'b0;
    chk("rst_done.resp_valid", resp_valid, 0);
    chk("rst_done.req_ready", req_ready, 1);
    chk("rst_done.op_count", op_count, exp_cnt);
    chk("rst_done.out", out, 0);

    // Directed vector table
    foreach (add_codes[i]) push(add_codes[i], 16'd1, 16'd1, 16'd2, 0, 1, 0, 0);
    foreach (sub_codes[i]) push(sub_codes[i], 16'd1, 16'd1, 16'd0, 1, 0, 0, 0);
    push(4'd0,  16'h7FFF, 16'h0001, 16'h8000, 0, 0, 1, 0);
    push(4'd1,  16'h8000, 16'h0001, 16'h7FFF, 0, 1, 1, 0);
    push(4'd0,  16'hFFFF, 16'h0001, 16'h0000, 1, 0, 0, 0);
    push(4'd0,  16'h8000, 16'h8000, 16'h0000, 1, 0, 1, 0);
    push(4'd5,  16'h7FFF, 16'hFFFF, 16'h8000, 0, 0, 1, 0);
    push(4'd12, 16'h0000, 16'h0001, 16'hFFFF, 0, 0, 0, 0);
    push(4'd13, 16'h1234, 16'h8001, 16'h8001, 0, 0, 0, 0);
    push(4'd13, 16'h7FFF, 16'h0000, 16'h0000, 1, 0, 0, 0);
    push(4'd14, 16'h0005, 16'h0005, 16'h0000, 1, 0, 0, 1);
    push(4'd15, 16'h7FFF, 16'h7FFF, 16'h0000, 1, 0, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      issue_wait(vecs[i].op, vecs[i].a, vecs[i].b, got, edges);
      if (i == 0) chk("latency_edges", edges, 2);
      check_resp($sformatf("vec%0d", i), vecs[i].e);
      consume();
    end

    // Backpressure: response held, new requests ignored
    e = model(4'd0, 16'h0100, 16'h0023);
    issue_wait(4'd0, 16'h0100, 16'h0023, got, edges);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_valid = 1'b1; inst_id = 4'd1; in0 = 16'($urandom); in1 = 16'($urandom);
      chk("bp.resp_valid", resp_valid, 1);
      chk("bp.req_ready", req_ready, 0);
      check_resp("bp", e);
    end
    @(negedge clk);
    req_valid = 1'b0;
    consume();
    check_resp("bp_idle_hold", e);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp.ignored_req", resp_valid, 0);
    end

    // Randomized operations against the reference model
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 5)] : 16'($urandom);
      b  = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 5)] : 16'($urandom);
      e  = model(op, a, b);
      issue_wait(op, a, b, got, edges);
      check_resp($sformatf("rnd%0d_op%0d", i, op), e);
      consume();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
